// File: rtl/aes_arb_pkg.sv
// Shared types and helpers for the AES core arbiter: FSM state encoding,
// default block width and the requester-ID width rule.
package aes_arb_pkg;

  localparam int AES_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  // A single requester still needs a 1-bit ID port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               any_req_o
);

  always_comb begin
    int idx;
    idx       = 0;
    gnt_o     = '0;
    gnt_id_o  = '0;
    any_req_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_req_o && req_i[idx]) begin
        any_req_o  = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core among NUM_REQ requesters with round-robin grants.
// Define AES_ARB_TIMEOUT_EN to add a RUN watchdog that aborts with resp_err.
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
`ifdef AES_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 64,
`endif
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = AES_DATA_W,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      AES_clk,
  input  logic                      AES_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*DATA_W-1:0] req_key,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic                      busy,
  output logic                      AES_en,
  output logic [DATA_W-1:0]         AES_data_in,
  output logic [DATA_W-1:0]         AES_key_in,
  input  logic [DATA_W-1:0]         AES_data_out,
  input  logic                      AES_data_out_valid
);

  arb_state_e          state_q;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   data_q, key_q, rdata_q;
  logic                en_q, rvld_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                any_req;
  logic [DATA_W-1:0]   sel_data, sel_key;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .any_req_o (any_req)
  );

  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_key  = req_key[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      key_q   <= '0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      rvld_q  <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            data_q  <= sel_data;
            key_q   <= sel_key;
            id_q    <= gnt_id;
            ptr_q   <= ptr_d;
            en_q    <= 1'b1;
            state_q <= RUN;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        RUN: begin
`ifdef AES_ARB_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
`endif
          // A result on the watchdog limit cycle still counts as a normal result.
          if (AES_data_out_valid) begin
            rdata_q <= AES_data_out;
            rvld_q  <= 1'b1;
            en_q    <= 1'b0;
            state_q <= RESP;
`ifdef AES_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            rdata_q <= '0;
            rvld_q  <= 1'b1;
            err_q   <= 1'b1;
            en_q    <= 1'b0;
            state_q <= RESP;
`endif
          end
        end
        RESP: begin
          rvld_q  <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
          state_q <= GAP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accept pulse is the grant itself, only visible in IDLE and outside reset.
  assign req_ready   = (state_q == IDLE && !AES_rst) ? gnt : '0;
  assign busy        = (state_q != IDLE);
  assign AES_en      = en_q;
  assign AES_data_in = data_q;
  assign AES_key_in  = key_q;
  assign resp_valid  = rvld_q;
  assign resp_id     = id_q;
  assign resp_data   = rdata_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a latency-programmable core model.
// Timeout cases are compiled in when AES_ARB_TIMEOUT_EN is defined.
module tb_aes_core_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int IW = 2;

  localparam logic [DW-1:0] P0 = 128'h00000020_00000000_00000000_00000000;
  localparam logic [DW-1:0] K0 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [DW-1:0] C0 = 128'haa2bdb60_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [DW-1:0] D1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [DW-1:0] D3 = 128'h33333333_33333333_33333333_33333333;
  localparam logic [DW-1:0] K3 = 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f;
  localparam logic [DW-1:0] C3 = 128'h3c3c3c3c_3c3c3c3c_3c3c3c3c_3c3c3c3c;
  localparam logic [DW-1:0] JUNK = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  logic            clk, rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*DW-1:0] req_data, req_key;
  logic            resp_valid, resp_err, busy, AES_en;
  logic [IW-1:0]   resp_id;
  logic [DW-1:0]   resp_data, AES_data_in, AES_key_in, core_out;
  logic            core_vld;

  int n_chk, n_pass;
  int cnum, en_run, lat;
  bit model_on, spur, auto_drop;
  logic [N-1:0] drop_mask;
  int en_cnt, resp_cnt, idle_cnt, last_en_cyc, resp_cyc;
  logic [IW-1:0] last_id;
  logic [DW-1:0] last_data;
  logic          last_err;
  int gnt_q[$];

  aes_core_arbiter dut (
    .AES_clk            (clk),
    .AES_rst            (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_data           (req_data),
    .req_key            (req_key),
    .resp_valid         (resp_valid),
    .resp_id            (resp_id),
    .resp_data          (resp_data),
    .resp_err           (resp_err),
    .busy               (busy),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (core_out),
    .AES_data_out_valid (core_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clr();
    en_cnt = 0; resp_cnt = 0; idle_cnt = 0; last_en_cyc = 0; resp_cyc = 0;
    gnt_q.delete();
  endtask

  // Called at a falling edge: drive the core model, observe the cycle, move to the next falling edge.
  task automatic cyc();
    if (AES_en) en_run++; else en_run = 0;
    core_vld  = (model_on && AES_en && en_run == lat + 1) || spur;
    core_out  = spur ? JUNK : (AES_data_in ^ AES_key_in);
    req_valid = req_valid & ~drop_mask;
    drop_mask = '0;
    #1;
    cnum++;
    if (req_ready != '0) begin
      chk("ready_onehot", DW'($onehot(req_ready)), 1);
      for (int i = 0; i < N; i++) if (req_ready[i]) gnt_q.push_back(i);
      if (auto_drop) drop_mask = req_ready;
    end
    if (AES_en) begin en_cnt++; last_en_cyc = cnum; end
    if (!busy) idle_cnt++;
    if (resp_valid) begin
      resp_cnt++; resp_cyc = cnum;
      last_id = resp_id; last_data = resp_data; last_err = resp_err;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input bit check);
    req_valid = '0; drop_mask = '0; spur = 1'b0; model_on = 1'b1; auto_drop = 1'b1;
    rst = 1'b1;
    cyc(); cyc();
    if (check) begin
      chk("rst_en", DW'(AES_en), 0);
      chk("rst_resp_valid", DW'(resp_valid), 0);
      chk("rst_busy", DW'(busy), 0);
      chk("rst_ready", DW'(req_ready), 0);
      chk("rst_resp_id", DW'(resp_id), 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_data_in", AES_data_in, 0);
      chk("rst_key_in", AES_key_in, 0);
      chk("rst_resp_err", DW'(resp_err), 0);
    end
    rst = 1'b0;
    clr();
  endtask

  task automatic wait_resp(input int n, input string tag);
    for (int t = 0; t < 300 && resp_cnt < n; t++) cyc();
    chk(tag, DW'(resp_cnt), DW'(n));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cnum = 0; en_run = 0; lat = 50;
    core_vld = 1'b0; core_out = '0; rst = 1'b1;
    req_valid = '0; req_data = '0; req_key = '0;
    last_id = '0; last_data = '0; last_err = 1'b0;
    @(negedge clk);

    // Single request, core answers 50 cycles after enable
    do_reset(1);
    req_data[0*DW +: DW] = P0; req_key[0*DW +: DW] = K0;
    req_valid = 4'b0001;
    wait_resp(1, "t1_resp_count");
    chk("t1_en_cycles", DW'(en_cnt), 51);
    chk("t1_resp_after_en", DW'(resp_cyc - last_en_cyc), 1);
    chk("t1_resp_id", DW'(last_id), 0);
    chk("t1_resp_data", last_data, C0);
    chk("t1_resp_err", DW'(last_err), 0);
    chk("t1_grants", DW'(gnt_q.size()), 1);
    chk("t1_data_in", AES_data_in, P0);
    chk("t1_key_in", AES_key_in, K0);

    // All four requesters held valid from reset
    do_reset(0);
    lat = 3; auto_drop = 1'b0;
    req_data[1*DW +: DW] = D1; req_key[1*DW +: DW] = '0;
    req_data[2*DW +: DW] = ~D1; req_key[2*DW +: DW] = '0;
    req_data[3*DW +: DW] = D3; req_key[3*DW +: DW] = K3;
    req_valid = 4'b1111;
    for (int t = 0; t < 200 && gnt_q.size() < 5; t++) cyc();
    chk("t2_grants", DW'(gnt_q.size()), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), DW'(gnt_q[i]), DW'(i % 4));
    chk("t2_idle_cycles", DW'(idle_cnt), 5);
    chk("t2_resp_count", DW'(resp_cnt), 4);
    chk("t2_last_id", DW'(last_id), 3);
    chk("t2_last_data", last_data, C3);

    // Fairness: after granting 1, requesters 1 and 3 together go 3 then 1
    do_reset(0);
    lat = 3;
    req_valid = 4'b0010;
    wait_resp(1, "t3_first_resp");
    req_valid = 4'b1010;
    for (int t = 0; t < 100 && gnt_q.size() < 3; t++) cyc();
    chk("t3_grants", DW'(gnt_q.size()), 3);
    chk("t3_g0", DW'(gnt_q[0]), 1);
    chk("t3_g1", DW'(gnt_q[1]), 3);
    chk("t3_g2", DW'(gnt_q[2]), 1);

    // Reset pulse in the middle of RUN
    do_reset(0);
    lat = 50;
    req_valid = 4'b0100;
    for (int t = 0; t < 6; t++) cyc();
    chk("t4_running", DW'(AES_en), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t4_en_after_rst", DW'(AES_en), 0);
    chk("t4_busy_after_rst", DW'(busy), 0);
    for (int t = 0; t < 60; t++) cyc();
    chk("t4_no_resp", DW'(resp_cnt), 0);
    req_valid = 4'b1001;
    for (int t = 0; t < 20 && gnt_q.size() < 2; t++) cyc();
    chk("t4_grants", DW'(gnt_q.size()), 2);
    chk("t4_ptr_cleared", DW'(gnt_q[1]), 0);
    req_valid = '0;
    wait_resp(1, "t4_resp_count");
    chk("t4_resp_id", DW'(last_id), 0);

    // Spurious core valid in GAP, then in IDLE
    spur = 1'b1; cyc();
    spur = 1'b0; cyc();
    spur = 1'b1; cyc();
    spur = 1'b0; cyc(); cyc();
    chk("t5_resp_count", DW'(resp_cnt), 1);
    chk("t5_grants", DW'(gnt_q.size()), 2);
    chk("t5_busy", DW'(busy), 0);
    chk("t5_en", DW'(AES_en), 0);
    chk("t5_resp_data", resp_data, C0);

`ifdef AES_ARB_TIMEOUT_EN
    // Silent core: watchdog aborts after 64 counted RUN cycles
    do_reset(0);
    model_on = 1'b0;
    req_valid = 4'b0001;
    wait_resp(1, "t6_resp_count");
    chk("t6_en_cycles", DW'(en_cnt), 65);
    chk("t6_resp_after_en", DW'(resp_cyc - last_en_cyc), 1);
    chk("t6_err", DW'(last_err), 1);
    chk("t6_data", last_data, 0);
    chk("t6_id", DW'(last_id), 0);
    cyc(); cyc();
    chk("t6_err_cleared", DW'(resp_err), 0);
    clr();
    // Result arriving exactly on the limit cycle wins
    model_on = 1'b1; lat = 64;
    req_valid = 4'b0010;
    wait_resp(1, "t7_resp_count");
    chk("t7_en_cycles", DW'(en_cnt), 65);
    chk("t7_err", DW'(last_err), 0);
    chk("t7_data", last_data, D1);
    chk("t7_id", DW'(last_id), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
